// File: rtl/alu_sequencer_pkg.sv
// Shared types and instruction-field helpers for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b1110;
    localparam logic [3:0] OP_MOVE = 4'b1111;

    // Instruction layout: [9:6] opcode, [5:3] Rx, [2:0] Ry
    localparam int OP_HI = 9;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    function automatic logic [3:0] op_of(input logic [9:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    function automatic logic [2:0] rx_of(input logic [9:0] instr);
        return instr[RX_HI:RX_LO];
    endfunction

    function automatic logic [2:0] ry_of(input logic [9:0] instr);
        return instr[RY_HI:RY_LO];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-control bundle between instruction source and sequencer.
interface alu_sequencer_if #(
    parameter int NREG = 8,
    parameter int W    = 10
);
    logic            Exec;
    logic [W-1:0]    INSTR;
    logic            Busy;
    logic            Done;
    logic            enA;
    logic            enGin;
    logic            enGout;
    logic            enExt;
    logic [3:0]      ALUcont;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;

    // Instruction source side
    modport master (
        output Exec, INSTR,
        input  Busy, Done, enA, enGin, enGout, enExt, ALUcont, Rin, Rout
    );

    // Sequencer side
    modport slave (
        input  Exec, INSTR,
        output Busy, Done, enA, enGin, enGout, enExt, ALUcont, Rin, Rout
    );
endinterface

// File: rtl/alu_sequencer_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all zero when disabled.
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign onehot[i] = en && (sel == 3'(i));
    end
endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the A/ALU/G datapath with an 8-register shared bus.
// LOAD and MOVE finish in one step, ALU ops take three (T1..T3).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 10
) (
    input  logic         CLK,
    input  logic         RST,
    alu_sequencer_if.slave bus
);

    state_t       state;
    state_t       next;
    logic [W-1:0] ir;

    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op = op_of(ir);
    assign rx = rx_of(ir);
    assign ry = ry_of(ir);

    logic       busy, done, en_a, en_gin, en_gout, en_ext;
    logic [3:0] alu_cont;
    logic       rin_en, rout_en;
    logic [2:0] rin_sel, rout_sel;
    logic [7:0] rin_vec, rout_vec;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    // Instruction register captures only on an accepted request
    always_ff @(posedge CLK) begin
        if (RST)                              ir <= '0;
        else if (state == IDLE && bus.Exec)   ir <= bus.INSTR;
    end

    // Next-state and Moore output decode from state and IR
    always_comb begin
        next     = state;
        busy     = 1'b0;
        done     = 1'b0;
        en_a     = 1'b0;
        en_gin   = 1'b0;
        en_gout  = 1'b0;
        en_ext   = 1'b0;
        alu_cont = 4'd0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_sel  = rx;
        rout_sel = ry;
        case (state)
            IDLE: begin
                if (bus.Exec) next = T1;
            end
            T1: begin
                busy   = 1'b1;
                rin_en = 1'b0;
                if (op == OP_LOAD) begin
                    en_ext = 1'b1;
                    rin_en = 1'b1;
                    done   = 1'b1;
                    next   = IDLE;
                end else if (op == OP_MOVE) begin
                    rout_en = 1'b1;
                    rin_en  = 1'b1;
                    done    = 1'b1;
                    next    = IDLE;
                end else begin
                    // First ALU step: Rx onto the bus into A
                    rout_sel = rx;
                    rout_en  = 1'b1;
                    en_a     = 1'b1;
                    next     = T2;
                end
            end
            T2: begin
                busy     = 1'b1;
                rout_en  = 1'b1;
                en_gin   = 1'b1;
                alu_cont = op;
                next     = T3;
            end
            T3: begin
                busy    = 1'b1;
                en_gout = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    dec3to8 u_rin  (.sel(rin_sel),  .en(rin_en),  .onehot(rin_vec));
    dec3to8 u_rout (.sel(rout_sel), .en(rout_en), .onehot(rout_vec));

    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.enA     = en_a;
    assign bus.enGin   = en_gin;
    assign bus.enGout  = en_gout;
    assign bus.enExt   = en_ext;
    assign bus.ALUcont = alu_cont;
    assign bus.Rin     = NREG'(rin_vec);
    assign bus.Rout    = NREG'(rout_vec);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control unit that drives the multi-stage ALU datapath: A register, ALU, G register, tristate G output, plus a bank of 8 general registers on a shared 10-bit bus.
- Accepts one 10-bit instruction per Exec request.
- Steps it through 1 or 3 timing states, producing register enables, bus-drive selects, ALU function code and a Done strobe.
- Sits between instruction source/testbench and the datapath top level.

Parameters:
- NREG, 8, number of general registers; width of Rin/Rout one-hot vectors; register select field = 3 bits (fixed for NREG=8).
- W, 10, instruction width; layout fixed: [9:6] opcode, [5:3] Rx, [2:0] Ry.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- Exec  input  1  request to start INSTR; sampled only in IDLE.
- INSTR  input  10  instruction word; latched on accepted Exec.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  high during final step cycle of an instruction.
- enA  output  1  A register load enable.
- enGin  output  1  G register load enable.
- enGout  output  1  G tristate drive onto bus.
- enExt  output  1  external data-in drive onto bus.
- ALUcont  output  4  ALU function code.
- Rin  output  NREG  one-hot general register load enables.
- Rout  output  NREG  one-hot general register bus-drive enables.

Behaviour:
- States: IDLE, T1, T2, T3. Instruction register IR (10 bits) and state are the only flops.
- Reset: RST=1 at a rising edge puts state in IDLE and IR at 0, regardless of state. All outputs then read 0: Busy, Done, enA, enGin, enGout, enExt, ALUcont, Rin, Rout. A reset mid-instruction aborts it with no Done.
- IDLE: if Exec=1, latch INSTR into IR and go to T1 next cycle. Otherwise stay. Exec is ignored when not in IDLE.
- Opcode decode, from IR[9:6]:
  - 4'b1110 is LOAD.
  - 4'b1111 is MOVE.
  - Any other value is an ALU op, passed through unchanged as ALUcont.
- LOAD:
  - T1: enExt=1, Rin[Rx]=1, Done=1.
  - Next state is IDLE.
- MOVE:
  - T1: Rout[Ry]=1, Rin[Rx]=1, Done=1.
  - Next state is IDLE.
- ALU op:
  - T1: Rout[Rx]=1, enA=1.
  - T2: Rout[Ry]=1, enGin=1, ALUcont=IR[9:6].
  - T3: enGout=1, Rin[Rx]=1, Done=1.
  - Next state is IDLE.
- Output timing:
  - All outputs are Moore-style decodes of state and IR; no output depends combinationally on Exec or INSTR.
  - ALUcont = 0 outside T2.
- Bus exclusivity: at most one of enExt, enGout, any Rout bit is high in any cycle. Rin and Rout are each at most one-hot.
- Rx == Ry is legal for both MOVE and ALU ops.
- Latency from Exec accepted at edge k: Done is high in cycle k+1 for LOAD/MOVE and in cycle k+3 for ALU ops. Busy stays high over the same span.
- Minimum issue interval: IDLE occupies at least one cycle between instructions. A held Exec restarts on the cycle after Done drops.
- Unreachable or illegal state encodings return to IDLE on the next edge.

Decomposition:
- Package alu_seq_pkg:
  - state enum (IDLE, T1, T2, T3).
  - opcode constants OP_LOAD=4'b1110, OP_MOVE=4'b1111.
  - instruction field slice constants.
- Sub-module dec3to8: 3-bit select plus enable to 8-bit one-hot, instantiated twice (Rin, Rout).

Test Plan:
1. Reset: hold RST 2 cycles, Exec=1 -> Busy=0, all enables 0, no state advance.
2. LOAD: INSTR=10'b1110_011_000, Exec pulse -> next cycle enExt=1, Rin=8'b0000_1000, Done=1. Following cycle Busy=0.
3. MOVE: INSTR=10'b1111_001_101 -> one cycle Rout=8'b0010_0000, Rin=8'b0000_0010, Done=1.
4. ALU op: INSTR=10'b0010_010_100 -> three cycles in order:
   - T1: Rout=8'b0000_0100, enA=1.
   - T2: Rout=8'b0001_0000, enGin=1, ALUcont=4'b0010.
   - T3: enGout=1, Rin=8'b0000_0100, Done=1.
   - Bus exclusivity is checked every cycle.
5. Exec held high with a new INSTR during T2 -> ignored; IR unchanged. A second Exec accepted only in IDLE gives the new instruction's T1 two cycles after the first Done.
6. RST asserted in T2 of an ALU op -> next cycle IDLE with all outputs 0 and no Done. Then LOAD executes normally.
